// File: rtl/pulse_cdc_multi_if.sv
//------------------------------------------------------------------------------
// Module      : pulse_cdc_multi_if
// Description : Event-strobe bundle for pulse_cdc_multi (clk_in-side strobes and
//               status, clk_out-side output strobes).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface pulse_cdc_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] pulse_in;
  logic [CHANNELS-1:0] pulse_out;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] ovf;
  logic                ovf_clr;

  modport master (
    output pulse_in,
    output ovf_clr,
    input  pulse_out,
    input  busy,
    input  ovf
  );

  modport slave (
    input  pulse_in,
    input  ovf_clr,
    output pulse_out,
    output busy,
    output ovf
  );
endinterface

`default_nettype wire

// File: rtl/pulse_cdc_multi.sv
//------------------------------------------------------------------------------
// Module      : pulse_cdc_multi
// Description : Lossless multi-channel pulse synchroniser clk_in -> clk_out using
//               toggle req/ack per channel with a saturating pending counter.
//               Optional macro PULSE_CDC_OVF_FLAG_EN compiles in the sticky
//               overflow flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pulse_cdc_multi #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  resetn_in,
  input  logic                  clk_out,
  input  logic                  resetn_out,
  pulse_cdc_multi_if.slave      bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [CHANNELS-1:0] w_pulse_out;
  logic [CHANNELS-1:0] w_busy;
  logic [CHANNELS-1:0] w_ovf;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Source-domain state
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_req_tgl;
    logic                   r_in_flight;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    // Destination-domain state
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_edge;
    logic                   r_pulse;

    logic w_pulse;
    logic w_cnt_nz;
    logic w_launch;
    logic w_done;
    logic w_lost;

    assign w_pulse  = bus.pulse_in[c];
    assign w_cnt_nz = (r_cnt != '0);
    assign w_launch = !r_in_flight && (w_cnt_nz || w_pulse);
    assign w_done   = r_in_flight && (r_ack_sync[SYNC_STAGES-1] == r_req_tgl);
    assign w_lost   = w_pulse && !w_launch && (r_cnt == c_cnt_max);

    always_ff @(posedge clk_in or negedge resetn_in) begin
      if (!resetn_in) begin
        r_cnt       <= '0;
        r_req_tgl   <= 1'b0;
        r_in_flight <= 1'b0;
        r_ack_sync  <= '0;
      end else begin
        r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_req_sync[SYNC_STAGES-1]};

        // Launch and completion are exclusive: launch requires !r_in_flight.
        if (w_launch) begin
          r_req_tgl   <= ~r_req_tgl;
          r_in_flight <= 1'b1;
        end else if (w_done) begin
          r_in_flight <= 1'b0;
        end

        // A pulse that launches directly never touches the counter.
        if (w_pulse && !w_launch && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (w_launch && !w_pulse) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end

    always_ff @(posedge clk_out or negedge resetn_out) begin
      if (!resetn_out) begin
        r_req_sync <= '0;
        r_edge     <= 1'b0;
        r_pulse    <= 1'b0;
      end else begin
        r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req_tgl};
        r_edge     <= r_req_sync[SYNC_STAGES-1];
        r_pulse    <= r_req_sync[SYNC_STAGES-1] ^ r_edge;
      end
    end

`ifdef PULSE_CDC_OVF_FLAG_EN
    logic r_ovf;

    // A new loss takes priority over a simultaneous clear.
    always_ff @(posedge clk_in or negedge resetn_in) begin
      if (!resetn_in) begin
        r_ovf <= 1'b0;
      end else if (w_lost) begin
        r_ovf <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end

    assign w_ovf[c] = r_ovf;
`else
    logic w_unused_lost;
    assign w_unused_lost = w_lost;
    assign w_ovf[c]      = 1'b0;
`endif

    assign w_pulse_out[c] = r_pulse;
    assign w_busy[c]      = r_in_flight | w_cnt_nz;
  end

`ifndef PULSE_CDC_OVF_FLAG_EN
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = bus.ovf_clr;
`endif

  assign bus.pulse_out = w_pulse_out;
  assign bus.busy      = w_busy;
  assign bus.ovf       = w_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pulse_cdc_multi.sv
//------------------------------------------------------------------------------
// Module      : tb_pulse_cdc_multi
// Description : Scoreboard bench for pulse_cdc_multi; expected strobes are queued
//               per channel at stimulus time and retired by an output monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_cdc_multi;
  localparam int CH  = 4;
  localparam int CW  = 4;
  localparam int SS  = 2;
  // One event in flight plus a full pending counter
  localparam int CAP = 1 << CW;

  logic clk_in     = 1'b0;
  logic clk_out    = 1'b0;
  logic resetn_in  = 1'b0;
  logic resetn_out = 1'b0;
  real  half_in    = 2.5;
  real  half_out   = 12.5;

  pulse_cdc_multi_if #(.CHANNELS(CH)) bus ();

  pulse_cdc_multi #(
    .CHANNELS    (CH),
    .CNT_W       (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_in     (clk_in),
    .resetn_in  (resetn_in),
    .clk_out    (clk_out),
    .resetn_out (resetn_out),
    .bus        (bus)
  );

  initial forever #(half_in) clk_in = ~clk_in;
  initial begin
    #1.3;
    forever #(half_out) clk_out = ~clk_out;
  end

  int checks = 0;
  int errors = 0;
  int exp_q [CH][$];
  int seq = 0;
  int out_edges = 0;
  int last_edge [CH];
  int seen_total = 0;
  logic [CH-1:0] prev_out = '0;

  always @(posedge clk_out) out_edges++;

  // Output monitor: every strobe must retire one queued event and last one cycle
  always @(negedge clk_out) begin
    for (int c = 0; c < CH; c++) begin
      if (bus.pulse_out[c]) begin
        checks++;
        if (prev_out[c]) begin
          errors++;
          $display("FAIL width ch%0d: pulse_out high two consecutive clk_out cycles, required 1", c);
        end
        checks++;
        if (exp_q[c].size() == 0) begin
          errors++;
          $display("FAIL spurious ch%0d: pulse_out=1 with no expected event, required 0", c);
        end else begin
          void'(exp_q[c].pop_front());
        end
        last_edge[c] = out_edges;
        seen_total++;
      end
    end
    prev_out = bus.pulse_out;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic expect_event(input int c);
    exp_q[c].push_back(seq);
    seq++;
  endtask

  function automatic int pending_total();
    int s = 0;
    for (int c = 0; c < CH; c++) s += exp_q[c].size();
    return s;
  endfunction

  task automatic step_in();
    @(posedge clk_in);
    #0.5;
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while ((pending_total() != 0 || bus.busy != '0) && n < max_cycles) begin
      step_in();
      n++;
    end
    chk({name, " pending events"}, pending_total(), 0);
    chk({name, " busy"}, int'(bus.busy), 0);
  endtask

  task automatic random_phase(input int cycles, input string name);
    logic [CH-1:0] m;
    for (int i = 0; i < cycles; i++) begin
      m = '0;
      for (int c = 0; c < CH; c++) begin
        // Keep occupancy well below capacity so no event can be lost
        if ($urandom_range(2) == 0 && exp_q[c].size() < 12) begin
          m[c] = 1'b1;
          expect_event(c);
        end
      end
      bus.pulse_in = m;
      step_in();
    end
    bus.pulse_in = '0;
    wait_drain(4000, name);
  endtask

  int launch_edge;
  int lat;
  int n;
  int seen_before;
  logic [CH-1:0] exp_ovf;

  initial begin
    bus.pulse_in = '0;
    bus.ovf_clr  = 1'b0;
    repeat (3) step_in();
    chk("reset pulse_out", int'(bus.pulse_out), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset ovf", int'(bus.ovf), 0);
    resetn_in  = 1'b1;
    resetn_out = 1'b1;
    repeat (5) step_in();

    // Single event on channel 2
    bus.pulse_in = 4'b0100;
    expect_event(2);
    @(posedge clk_in);
    launch_edge = out_edges;
    #0.5;
    bus.pulse_in = '0;
    chk("single busy set", int'(bus.busy), 4'b0100);
    n = 0;
    while (exp_q[2].size() != 0 && n < 200) begin
      step_in();
      n++;
    end
    lat = last_edge[2] - launch_edge;
    checks++;
    if (exp_q[2].size() != 0 || lat < SS + 1 || lat > SS + 2) begin
      errors++;
      $display("FAIL single latency: got %0d clk_out edges, required %0d..%0d", lat, SS + 1, SS + 2);
    end
    wait_drain(400, "single");

    // Burst of 10 on channel 0
    for (int i = 0; i < 10; i++) begin
      bus.pulse_in = 4'b0001;
      expect_event(0);
      step_in();
    end
    bus.pulse_in = '0;
    wait_drain(4000, "burst");
    chk("burst ovf", int'(bus.ovf), 0);

    // Saturation: slow clk_out so nothing completes during the 20 pulses
    half_out = 250.0;
    for (int i = 0; i < ((20 < CAP) ? 20 : CAP); i++) expect_event(0);
    for (int i = 0; i < 20; i++) begin
      bus.pulse_in = 4'b0001;
      step_in();
    end
    bus.pulse_in = '0;
`ifdef PULSE_CDC_OVF_FLAG_EN
    exp_ovf = (20 > CAP) ? 4'b0001 : 4'b0000;
`else
    exp_ovf = 4'b0000;
`endif
    chk("sat ovf", int'(bus.ovf), int'(exp_ovf));
    chk("sat busy", int'(bus.busy), 4'b0001);
    bus.ovf_clr = 1'b1;
    step_in();
    bus.ovf_clr = 1'b0;
    chk("ovf after clr", int'(bus.ovf), 0);
    half_out = 12.5;
    wait_drain(20000, "sat");

    // Reset with one in flight and five pending; those events are discarded
    half_out = 250.0;
    for (int i = 0; i < 6; i++) begin
      bus.pulse_in = 4'b0010;
      step_in();
    end
    bus.pulse_in = '0;
    step_in();
    chk("pre-reset busy", int'(bus.busy), 4'b0010);
    resetn_in  = 1'b0;
    resetn_out = 1'b0;
    #1;
    chk("in reset pulse_out", int'(bus.pulse_out), 0);
    chk("in reset busy", int'(bus.busy), 0);
    chk("in reset ovf", int'(bus.ovf), 0);
    half_out = 12.5;
    repeat (4) @(posedge clk_out);
    step_in();
    resetn_in  = 1'b1;
    resetn_out = 1'b1;
    seen_before = seen_total;
    repeat (40) @(posedge clk_out);
    #1;
    chk("post-reset strobes", seen_total - seen_before, 0);
    chk("post-reset busy", int'(bus.busy), 0);
    step_in();
    bus.pulse_in = 4'b0010;
    expect_event(1);
    step_in();
    bus.pulse_in = '0;
    wait_drain(400, "post-reset event");

    // Reversed ratio (clk_in 40 MHz, clk_out 200 MHz), then forward ratio
    half_in  = 12.5;
    half_out = 2.5;
    repeat (4) step_in();
    random_phase(300, "rand slow-in");
    half_in  = 2.5;
    half_out = 12.5;
    repeat (4) step_in();
    random_phase(600, "rand fast-in");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
